lfsr_seq_gen: RTL and testbench

//  Parametrised Fibonacci LFSR sequence generator for the game core.

---
 rtl/game_pkg.sv | 9 +
 rtl/lfsr_step_comb.sv | 16 +
 rtl/lfsr_seq_gen.sv | 59 +++++
 tb/tb_lfsr_seq_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared constants and types for the game core sequence generator.
package game_pkg;
    localparam int LFSR_W = 8;
    localparam int SYM_W = 2;
    localparam logic [LFSR_W-1:0] LFSR_TAPS_DEF = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 8'h01;
    typedef logic [LFSR_W-1:0] lfsr_state_t;
    typedef logic [SYM_W-1:0] symbol_t;
endpackage

// File: rtl/lfsr_step_comb.sv
// lfsr_step_comb: applies STEP unrolled Fibonacci LFSR shifts combinationally.
module lfsr_step_comb #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8,
    parameter int STEP = 1
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);
    logic [WIDTH-1:0] chain [STEP+1];
    assign chain[0] = state_in;
    for (genvar i = 0; i < STEP; i++) begin : g_shift
        assign chain[i+1] = {chain[i][WIDTH-2:0], ^(chain[i] & TAPS)};
    end
    assign state_out = chain[STEP];
endmodule

// File: rtl/lfsr_seq_gen.sv
// lfsr_seq_gen: seedable LFSR symbol generator with checkpoint/rewind replay.
module lfsr_seq_gen
    import game_pkg::*;
#(
    parameter int WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS = LFSR_TAPS_DEF,
    parameter logic [WIDTH-1:0] SEED = LFSR_SEED_DEF,
    parameter int STEP = SYM_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             mark,
    input  logic             rewind,
    input  logic             advance,
    output logic [WIDTH-1:0] state_out,
    output logic [STEP-1:0]  symbol,
    output logic [CNT_W-1:0] draw_cnt,
    output logic             seed_zero
);
    logic [WIDTH-1:0] ckpt, stepped, load_val;
    logic             seed_is_zero;

    lfsr_step_comb #(.WIDTH(WIDTH), .TAPS(TAPS), .STEP(STEP)) u_step (
        .state_in (state_out),
        .state_out(stepped)
    );

    // A zero seed would lock the LFSR, so it falls back to SEED.
    assign seed_is_zero = (seed_in == '0);
    assign load_val = seed_is_zero ? SEED : seed_in;
    assign symbol = state_out[STEP-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_out <= SEED;
            ckpt <= SEED;
            draw_cnt <= '0;
            seed_zero <= 1'b0;
        end else begin
            seed_zero <= seed_load && seed_is_zero;
            if (seed_load) begin
                state_out <= load_val;
                ckpt <= load_val;
                draw_cnt <= '0;
            end else if (rewind) begin
                state_out <= ckpt;
                draw_cnt <= '0;
            end else begin
                if (mark) ckpt <= state_out;
                if (advance) state_out <= stepped;
                if (mark) draw_cnt <= {{(CNT_W-1){1'b0}}, advance};
                else if (advance && !(&draw_cnt)) draw_cnt <= draw_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_seq_gen.sv
// tb_lfsr_seq_gen: directed checks of a STEP=1/CNT_W=4 instance and a default instance.
module tb_lfsr_seq_gen;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0, seed_load = 1'b0, mark = 1'b0, rewind = 1'b0, advance = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic [7:0] st1, st2;
    logic [0:0] sym1;
    logic [1:0] sym2;
    logic [3:0] cnt1;
    logic [7:0] cnt2;
    logic sz1, sz2;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    lfsr_seq_gen #(.STEP(1), .CNT_W(4)) d1 (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
        .mark(mark), .rewind(rewind), .advance(advance),
        .state_out(st1), .symbol(sym1), .draw_cnt(cnt1), .seed_zero(sz1)
    );
    lfsr_seq_gen d2 (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
        .mark(mark), .rewind(rewind), .advance(advance),
        .state_out(st2), .symbol(sym2), .draw_cnt(cnt2), .seed_zero(sz2)
    );

    function automatic logic [7:0] sh(logic [7:0] s, int n);
        for (int i = 0; i < n; i++) s = {s[6:0], ^(s & 8'hB8)};
        return s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp1 [5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        logic [7:0] exp2 [5] = '{8'h04, 8'h11, 8'h47, 8'h1C, 8'h71};
        logic [1:0] rec [5];
        int first, zeros;
        // reset
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst_state1", st1, 8'h01);
        chk("rst_state2", st2, 8'h01);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_sz1", sz1, 0);
        // four advances
        advance = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("adv_st1_%0d", i), st1, exp1[i]);
            chk($sformatf("adv_st2_%0d", i), st2, exp2[i]);
        end
        advance = 1'b0;
        chk("adv_cnt1", cnt1, 4);
        chk("adv_cnt2", cnt2, 4);
        cyc();
        chk("hold_st1", st1, 8'h11);
        // mark / rewind replay
        reset = 1'b1; cyc(); reset = 1'b0;
        mark = 1'b1; cyc(); mark = 1'b0;
        chk("mark_cnt2", cnt2, 0);
        advance = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            rec[i] = sym2;
            chk($sformatf("pass1_sym_%0d", i), sym2, exp2[i][1:0]);
            chk($sformatf("pass1_st1_%0d", i), st1, exp1[i]);
        end
        advance = 1'b0;
        rewind = 1'b1; cyc(); rewind = 1'b0;
        chk("rew_st1", st1, 8'h01);
        chk("rew_st2", st2, 8'h01);
        chk("rew_cnt2", cnt2, 0);
        advance = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("pass2_sym_%0d", i), sym2, rec[i]);
        end
        advance = 1'b0;
        // seeding
        seed_load = 1'b1; seed_in = 8'h00; cyc(); seed_load = 1'b0;
        chk("zseed_st1", st1, 8'h01);
        chk("zseed_st2", st2, 8'h01);
        chk("zseed_sz1", sz1, 1);
        chk("zseed_cnt2", cnt2, 0);
        cyc();
        chk("zseed_sz1_off", sz1, 0);
        seed_load = 1'b1; seed_in = 8'h5A; cyc(); seed_load = 1'b0;
        chk("seed_st2", st2, 8'h5A);
        chk("seed_sz2", sz2, 0);
        // seed beats rewind and advance
        seed_load = 1'b1; rewind = 1'b1; advance = 1'b1; seed_in = 8'h33; cyc();
        seed_load = 1'b0; rewind = 1'b0;
        chk("prio_st1", st1, 8'h33);
        chk("prio_st2", st2, 8'h33);
        chk("prio_cnt2", cnt2, 0);
        cyc(); cyc();
        chk("pre_mark_st1", st1, sh(8'h33, 2));
        mark = 1'b1; cyc(); mark = 1'b0;
        chk("markadv_st1", st1, sh(8'h33, 3));
        chk("markadv_cnt1", cnt1, 1);
        chk("markadv_cnt2", cnt2, 1);
        cyc(); cyc(); advance = 1'b0;
        chk("markadv_cnt_later", cnt1, 3);
        rewind = 1'b1; cyc(); rewind = 1'b0;
        chk("markadv_rew_st1", st1, sh(8'h33, 2));
        chk("markadv_rew_st2", st2, sh(8'h33, 4));
        // full period and counter saturation
        reset = 1'b1; cyc(); reset = 1'b0;
        first = 0; zeros = 0;
        advance = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            cyc();
            if (i <= 255) chk($sformatf("period_st_%0d", i), st1, sh(8'h01, i));
            if (st1 == 8'h00) zeros++;
            if (st1 == 8'h01 && first == 0) first = i;
            if (i == 14) chk("sat_cnt_14", cnt1, 14);
            if (i == 16) chk("sat_cnt_16", cnt1, 15);
        end
        advance = 1'b0;
        chk("period_first_repeat", first, 255);
        chk("period_no_zero", zeros, 0);
        chk("sat_cnt_end", cnt1, 15);
        chk("cnt2_end", cnt2, 255);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
